// File: rtl/xgmii_rx_fault_ctrl.sv
// rtl/xgmii_rx_fault_ctrl.sv - XGMII 128-bit receive link-fault sequencing controller
module xgmii_rx_fault_ctrl #(
    parameter int DATA_WIDTH     = 128,
    parameter int CTRL_WIDTH     = DATA_WIDTH / 8,
    parameter int HOLDOFF_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] xgmii_rxd,
    input  logic [CTRL_WIDTH-1:0] xgmii_rxc,
    input  logic                  cfg_rx_enable_req,
    output logic                  rx_enable,
    output logic                  link_up,
    output logic [1:0]            link_status,
    output logic                  tx_send_rfault,
    output logic                  tx_send_idle,
    output logic                  stat_fault_event
);

    typedef enum logic [1:0] {ST_OK, ST_LOCAL, ST_REMOTE, ST_HOLDOFF} state_t;
    typedef enum logic [1:0] {EV_NONE, EV_DECL_LOCAL, EV_DECL_REMOTE, EV_CLEAR} event_t;

    localparam logic [15:0] HOLD_LOAD = 16'(HOLDOFF_CYCLES);

    logic [DATA_WIDTH-1:0] rxd_r;
    logic [CTRL_WIDTH-1:0] rxc_r;
    logic                  req_r;

    logic [7:0]  col_cnt, col_n;
    logic [2:0]  seq_cnt, seq_n;
    logic        last_type, type_n;   // 0 = local, 1 = remote
    logic [1:0]  ct;
    event_t      ev;

    state_t      state, state_n;
    logic [15:0] hold_cnt, hold_n;
    logic        pulse_n;

    // Returns 2'b01 for a local-fault column, 2'b10 for remote, 2'b00 otherwise.
    function automatic logic [1:0] col_type(input logic [31:0] d, input logic [3:0] c);
        col_type = 2'b00;
        if (c == 4'b0001 && d[7:0] == 8'h9C && d[23:8] == 16'h0000 &&
            (d[31:24] == 8'h01 || d[31:24] == 8'h02))
            col_type = d[25:24];
    endfunction

    // Columns are walked in order so later columns see earlier updates; the last event wins.
    always_comb begin
        col_n  = col_cnt;
        seq_n  = seq_cnt;
        type_n = last_type;
        ev     = EV_NONE;
        ct     = 2'b00;
        for (int c = 0; c < 4; c++) begin
            ct = col_type(rxd_r[32*c +: 32], rxc_r[4*c +: 4]);
            if (ct != 2'b00) begin
                col_n = 8'd0;
                if (ct[1] == type_n && seq_n != 3'd0) begin
                    if (seq_n != 3'd4)
                        seq_n = seq_n + 3'd1;
                end else begin
                    type_n = ct[1];
                    seq_n  = 3'd1;
                end
                if (seq_n == 3'd4)
                    ev = ct[1] ? EV_DECL_REMOTE : EV_DECL_LOCAL;
            end else if (col_n < 8'd128) begin
                col_n = col_n + 8'd1;
                if (col_n == 8'd128) begin
                    seq_n = 3'd0;
                    ev    = EV_CLEAR;
                end
            end
        end
    end

    always_comb begin
        state_n = state;
        hold_n  = hold_cnt;
        case (ev)
            EV_DECL_LOCAL:  state_n = ST_LOCAL;
            EV_DECL_REMOTE: state_n = ST_REMOTE;
            EV_CLEAR: begin
                if (state == ST_LOCAL || state == ST_REMOTE) begin
                    if (HOLD_LOAD == 16'd0) begin
                        state_n = ST_OK;
                    end else begin
                        state_n = ST_HOLDOFF;
                        hold_n  = HOLD_LOAD;
                    end
                end
            end
            default: begin
                if (state == ST_HOLDOFF) begin
                    if (hold_cnt <= 16'd1) begin
                        state_n = ST_OK;
                        hold_n  = 16'd0;
                    end else begin
                        hold_n = hold_cnt - 16'd1;
                    end
                end
            end
        endcase
        pulse_n = (state_n == ST_LOCAL || state_n == ST_REMOTE) && (state_n != state);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_r            <= '0;
            rxc_r            <= '0;
            req_r            <= 1'b0;
            col_cnt          <= 8'd128;
            seq_cnt          <= 3'd0;
            last_type        <= 1'b0;
            state            <= ST_OK;
            hold_cnt         <= 16'd0;
            stat_fault_event <= 1'b0;
        end else begin
            rxd_r            <= xgmii_rxd;
            rxc_r            <= xgmii_rxc;
            req_r            <= cfg_rx_enable_req;
            col_cnt          <= col_n;
            seq_cnt          <= seq_n;
            last_type        <= type_n;
            state            <= state_n;
            hold_cnt         <= hold_n;
            stat_fault_event <= pulse_n;
        end
    end

    assign link_up        = (state == ST_OK);
    assign rx_enable      = req_r & (state == ST_OK);
    assign tx_send_rfault = (state == ST_LOCAL);
    assign tx_send_idle   = (state == ST_REMOTE);
    assign link_status    = (state == ST_LOCAL)  ? 2'b01 :
                            (state == ST_REMOTE) ? 2'b10 : 2'b00;

endmodule

// File: doc/xgmii_rx_fault_ctrl.md
# xgmii_rx_fault_ctrl

Link-fault sequencing controller for the 128-bit XGMII receive path, per IEEE 802.3 Clause 46 Reconciliation Sublayer rules. It sits beside the 128-bit XGMII frame receiver and taps the same `xgmii_rxd`/`xgmii_rxc` bus. It detects local/remote fault ordered sets and tracks link fault state. It drives the receiver's `cfg_rx_enable` and the transmitter's fault-response controls.

## Interface
- `DATA_WIDTH`, 128, XGMII data width; only 128 is legal.
- `CTRL_WIDTH`, `DATA_WIDTH/8`, XGMII control width.
- `HOLDOFF_CYCLES`, 16, clock cycles spent in HOLDOFF after a fault clears before the link is reported up; range 0..65535.
- `clk`  input  1  single clock for all logic.
- `rst`  input  1  synchronous, active-high reset.
- `xgmii_rxd`  input  128  XGMII receive data, lane j = bits [8j+7:8j].
- `xgmii_rxc`  input  16  XGMII receive control, bit j qualifies lane j.
- `cfg_rx_enable_req`  input  1  software request to enable reception.
- `rx_enable`  output  1  gated enable to the receiver's `cfg_rx_enable`.
- `link_up`  output  1  high only in state OK.
- `link_status`  output  2  00 = OK/HOLDOFF, 01 = local fault, 10 = remote fault.
- `tx_send_rfault`  output  1  transmitter must send remote-fault ordered sets.
- `tx_send_idle`  output  1  transmitter must send idles only.
- `stat_fault_event`  output  1  one-cycle pulse on each entry into a fault state.

## Operation
- Input stage: `xgmii_rxd`/`xgmii_rxc` are registered once; all processing uses the registered copy.
- Columns: each word holds 4 columns, c = 0..3, starting at lane 4c. Columns are processed in order c = 0,1,2,3 within one cycle, so the effect is sequential per column.
- A column is a fault sequence when all of these hold: rxc[4c] = 1 and lane 4c = 0x9C; rxc[4c+3:4c+1] = 0; lanes 4c+1 and 4c+2 = 0x00; lane 4c+3 is 0x01 (type LOCAL) or 0x02 (type REMOTE). Any other column is a non-sequence column.
- Registers: `col_cnt` (8 bit, saturates at 128), `seq_cnt` (3 bit, saturates at 4), `last_type`.
- Fault-sequence column of type T:
  - `col_cnt` ← 0.
  - If T == `last_type` and `seq_cnt` ≠ 0: `seq_cnt` ← min(`seq_cnt`+1, 4). Otherwise `last_type` ← T and `seq_cnt` ← 1.
  - When `seq_cnt` becomes or stays at 4, a declare(T) event occurs.
- Non-sequence column: `col_cnt` increments while < 128. On the 127 → 128 step, `seq_cnt` ← 0 and a clear event occurs. At 128 there is no further event.
- States: OK, LOCAL, REMOTE, HOLDOFF.
  - declare(LOCAL) from any state → LOCAL; declare(REMOTE) from any state → REMOTE.
  - clear in LOCAL/REMOTE → HOLDOFF and load the holdoff counter with `HOLDOFF_CYCLES`. If `HOLDOFF_CYCLES` = 0, go directly to OK.
  - clear in OK/HOLDOFF: no effect.
  - HOLDOFF decrements once per cycle with no event → OK when it reaches 0.
- Multiple events in one cycle: the event of the highest-numbered column wins.
- Outputs are decoded from registered state:
  - `rx_enable` = `cfg_rx_enable_req` & (state == OK).
  - `tx_send_rfault` = LOCAL; `tx_send_idle` = REMOTE.
  - `stat_fault_event` = transition into LOCAL/REMOTE from a different state. LOCAL→LOCAL re-declarations do not pulse.

## Timing
- Reset values: state OK, `col_cnt` = 128, `seq_cnt` = 0, `last_type` = LOCAL, holdoff counter = 0. Outputs after reset: `link_up` 1, `link_status` 00, `rx_enable` = `cfg_rx_enable_req` from the next cycle, `tx_send_rfault` 0, `tx_send_idle` 0, `stat_fault_event` 0.
- Latency:
  - A word presented in cycle N affects state after the 2nd rising edge, i.e. outputs change in cycle N+2.
  - `cfg_rx_enable_req` → `rx_enable`: 1 cycle (registered).
- Reset mid-fault: returns to the reset values immediately and discards all count history.
- No handshake; one word is consumed every cycle and no backpressure exists.

## Test plan
- Reset with `cfg_rx_enable_req` = 1 and idle input (all lanes 0x07, rxc = FFFF) → `link_up` = 1, `rx_enable` = 1, `link_status` = 00, no pulses.
- One word with local-fault sets in columns 0..3 (0x9C,00,00,01 ×4) → in cycle N+2: `link_status` = 01, `tx_send_rfault` = 1, `rx_enable` = 0, `stat_fault_event` pulses once.
- 3 local sets, then 2 remote sets, then 2 more remote sets within 128 columns → REMOTE declared on the 4th remote set; `tx_send_idle` = 1, `link_status` = 10.
- In LOCAL, apply 32 idle words (128 columns) with `HOLDOFF_CYCLES` = 16 → HOLDOFF after the 32nd word, `link_status` = 00, `link_up` = 0; `link_up` = 1 exactly 16 cycles later.
- 3 local sets, 128 idle columns, then 1 local set → no declaration, because `seq_cnt` restarts at 1.
- In HOLDOFF, 4 remote sets → REMOTE immediately with a `stat_fault_event` pulse; assert `rst` mid-REMOTE → OK on the next cycle.
